wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 18, is the result/register data width.
REQ-002 Parameter ADDR_W, default 4, is the register-file address width.
REQ-003 Parameter DEPTH, default 2, is the number of buffered long-latency result entries.
REQ-004 Parameter STARVE_MAX, default 4, is the starvation threshold in cycles (range 1..15).
REQ-005 The block shall have one clock and a synchronous, active-high reset: clk, rst.
REQ-006 Ports shall be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RegWriteW  in  1  pipeline writeback write enable
- RdW  in  ADDR_W  pipeline destination register
- ResultW  in  DATA_W  pipeline writeback result
- lu_valid  in  1  long-latency unit result valid
- lu_ready  out  1  arbiter can accept a long-latency result
- lu_rd  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- stall_o  out  1  request to the hazard unit for one writeback bubble
- pend_mask  out  2**ADDR_W  one bit per register with a buffered, unwritten result

Function
REQ-007 The pipeline path shall have absolute priority. When RegWriteW=1, the port shall present rf_we=1, rf_waddr=RdW and rf_wdata=ResultW in the same cycle, with zero latency (combinational).
REQ-008 A long-latency result shall be accepted into the FIFO on a clock edge where lu_valid=1 and lu_ready=1.
REQ-009 lu_ready shall equal (count < DEPTH). It shall be registered-count based, with no pass-through when full.
REQ-010 When RegWriteW=0 and the FIFO is non-empty, the port shall write the FIFO head (rf_we=1, head address and data), and the head shall be popped at that edge.
REQ-011 When RegWriteW=0 and the FIFO is empty, the outputs shall be rf_we=0, rf_waddr=0 and rf_wdata=0.
REQ-012 A push and a pop in the same cycle shall leave count unchanged and preserve FIFO order. The read and write pointers shall wrap modulo DEPTH.
REQ-013 pend_mask shall be the OR of the one-hot destination bits of all valid FIFO entries. It shall update on the edge after a push or pop.
REQ-014 The starvation counter shall increment each cycle in which the FIFO is non-empty and RegWriteW=1, and shall clear in any cycle in which the FIFO is empty or a pop occurs.
REQ-015 When the counter reaches STARVE_MAX, stall_o shall be registered high for exactly one cycle and the counter shall clear.
REQ-016 In the cycle after stall_o=1, the hazard unit guarantees RegWriteW=0, so the FIFO head shall drain in that cycle.
REQ-017 The hazard unit uses pend_mask to prevent issue of instructions writing or reading a pending register. The arbiter shall not reorder writes to the same register.
REQ-018 lu_valid while lu_ready=0 shall not push and shall not corrupt state; the unit holds its data until accepted.

Reset
REQ-019 On a clk edge with rst=1, the following shall be cleared: count=0, pointers=0, all entry valid bits=0, starvation counter=0, stall_o=0.
REQ-020 During rst, rf_we shall be forced to 0 and lu_ready to 0, regardless of RegWriteW.
REQ-021 Reset asserted mid-operation shall discard all buffered results. pend_mask shall read 0 on the cycle after reset.

Structure
REQ-022 Package wb_pkg shall hold DATA_W/ADDR_W defaults and the wb_entry_t struct {rd, data}.
REQ-023 Sub-module wb_fifo (DEPTH entries, push/pop/count/head, valid vector) shall hold the buffer. Priority, drain and starvation logic shall reside in wb_port_arbiter.

Verification
REQ-024 Stimulus: reset, then RegWriteW=1, RdW=3, ResultW=0x2A. Required response: same cycle rf_we=1, rf_waddr=3, rf_wdata=0x2A; stall_o=0.
REQ-025 Stimulus: lu_valid with rd=5, data=0x3FFFF, while RegWriteW=0. Required response: next cycle rf_we=1, rf_waddr=5, rf_wdata=0x3FFFF; pend_mask[5] set for one cycle, then cleared.
REQ-026 Stimulus: two pushes (rd=1, then rd=2) while RegWriteW=1. Required response: lu_ready=0 after the second push; a third lu_valid is held; drain order is 1 then 2.
REQ-027 Stimulus: FIFO non-empty with RegWriteW=1 for 4 cycles. Required response: stall_o=1 exactly one cycle later; the next cycle with RegWriteW=0 writes the head.
REQ-028 Stimulus: push and pop in the same cycle at count=1. Required response: count stays 1; data order is preserved.
REQ-029 Stimulus: rst asserted with 2 entries buffered. Required response: the next cycle shows rf_we=0, pend_mask=0, lu_ready=1 after rst is released; no stale write occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the buffered writeback entry layout for the writeback port arbiter.
package wb_pkg;
  localparam int WB_DATA_W = 18;
  localparam int WB_ADDR_W = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for long-latency results; exposes every slot plus a valid
// vector so the owner can build a pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic [DEPTH-1:0]           valid,
  output entry_t [DEPTH-1:0]         entries
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  entry_t [DEPTH-1:0] mem;
  logic   [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Push and pop never target the same slot: that would need count==0 and
  // count==DEPTH at once, since push is gated by full and pop by empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]   <= din;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= nxt(rd_ptr);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign entries = mem;
endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline writeback (always wins)
// and buffered long-latency results, with a starvation bubble request.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWriteW,
  input  logic [ADDR_W-1:0]      RdW,
  input  logic [DATA_W-1:0]      ResultW,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [ADDR_W-1:0]      lu_rd,
  input  logic [DATA_W-1:0]      lu_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   stall_o,
  output logic [(1<<ADDR_W)-1:0] pend_mask
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               head;
  entry_t [DEPTH-1:0]   entries;
  logic   [CW-1:0]      count;
  logic                 empty, push, pop;
  logic   [DEPTH-1:0]   valid;
  logic   [3:0]         starve_cnt;

  assign lu_ready = !rst && (count < CW'(DEPTH));
  assign push     = lu_valid && lu_ready;
  assign pop      = !rst && !RegWriteW && !empty;

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     ('{rd: lu_rd, data: lu_data}),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .valid   (valid),
    .entries (entries)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (RegWriteW) begin
        rf_we    = 1'b1;
        rf_waddr = RdW;
        rf_wdata = ResultW;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) pend_mask[entries[i].rd] = 1'b1;
  end

  // Counts cycles the head is blocked by the pipeline; on threshold asks the
  // hazard unit for one bubble, in which the head drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_o    <= 1'b0;
    end else begin
      stall_o <= 1'b0;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt + 4'd1 == 4'(STARVE_MAX)) begin
        starve_cnt <= '0;
        stall_o    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven check of the writeback port arbiter: one record per cycle.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, RegWriteW, lu_valid, lu_ready, rf_we, stall_o;
  logic [3:0]  RdW, lu_rd, rf_waddr;
  logic [17:0] ResultW, lu_data, rf_wdata;
  logic [15:0] pend_mask;

  int n_chk = 0;
  int n_err = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_o(stall_o), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rw;
    logic [3:0]  rd;
    logic [17:0] res;
    logic        lv;
    logic [3:0]  lrd;
    logic [17:0] ldat;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [17:0] e_data;
    logic        e_rdy, e_stall;
    logic [15:0] e_mask;
    logic        chk_wd, chk_mask;
  } vec_t;

  function automatic vec_t mk(logic r, logic rw, logic [3:0] rd, logic [17:0] res,
                              logic lv, logic [3:0] lrd, logic [17:0] ldat,
                              logic ewe, logic [3:0] ea, logic [17:0] ed,
                              logic erdy, logic est, logic [15:0] em,
                              logic cwd = 1'b1, logic cm = 1'b1);
    vec_t v;
    v.rst = r; v.rw = rw; v.rd = rd; v.res = res;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
    v.e_rdy = erdy; v.e_stall = est; v.e_mask = em;
    v.chk_wd = cwd; v.chk_mask = cm;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs, sample mid-cycle, then advance past the edge.
  task automatic run_vec(input vec_t v, input string nm, input int idx);
    rst = v.rst; RegWriteW = v.rw; RdW = v.rd; ResultW = v.res;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ldat;
    @(negedge clk);
    check({nm, ".rf_we"},    idx, 32'(rf_we),    32'(v.e_we));
    check({nm, ".lu_ready"}, idx, 32'(lu_ready), 32'(v.e_rdy));
    check({nm, ".stall_o"},  idx, 32'(stall_o),  32'(v.e_stall));
    if (v.chk_mask) check({nm, ".pend_mask"}, idx, 32'(pend_mask), 32'(v.e_mask));
    if (v.chk_wd) begin
      check({nm, ".rf_waddr"}, idx, 32'(rf_waddr), 32'(v.e_addr));
      check({nm, ".rf_wdata"}, idx, 32'(rf_wdata), 32'(v.e_data));
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[12];
  vec_t seq[$];

  initial begin
    rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    @(posedge clk); #1;

    //            rst rw rd   res       lv lrd  ldat      we addr data      rdy st mask
    tbl[0]  = mk(1, 1, 3, 18'h00007, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 16'h0000, 0, 1);
    tbl[1]  = mk(0, 1, 3, 18'h0002A, 0, 0, 18'h0,     1, 3, 18'h0002A, 1, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 18'h0,     1, 5, 18'h3FFFF, 0, 0, 18'h0,     1, 0, 16'h0000);
    tbl[3]  = mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     1, 5, 18'h3FFFF, 1, 0, 16'h0020);
    tbl[4]  = mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 18'h0,     1, 0, 16'h0000);
    tbl[5]  = mk(0, 1, 8, 18'h00100, 1, 1, 18'h00011, 1, 8, 18'h00100, 1, 0, 16'h0000);
    tbl[6]  = mk(0, 1, 9, 18'h00101, 1, 2, 18'h00022, 1, 9, 18'h00101, 1, 0, 16'h0002);
    tbl[7]  = mk(0, 1,10, 18'h00102, 1, 3, 18'h00033, 1,10, 18'h00102, 0, 0, 16'h0006);
    tbl[8]  = mk(0, 0, 0, 18'h0,     1, 3, 18'h00033, 1, 1, 18'h00011, 0, 0, 16'h0006);
    tbl[9]  = mk(0, 0, 0, 18'h0,     1, 3, 18'h00033, 1, 2, 18'h00022, 1, 0, 16'h0004);
    tbl[10] = mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     1, 3, 18'h00033, 1, 0, 16'h0008);
    tbl[11] = mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 18'h0,     1, 0, 16'h0000);
    for (int i = 0; i < 12; i++) run_vec(tbl[i], "tbl", i);

    // Starvation: head blocked for 4 cycles, then one bubble drains it.
    seq.delete();
    seq.push_back(mk(0, 0, 0, 18'h0,     1, 6, 18'h00066, 0, 0, 18'h0,     1, 0, 16'h0000));
    seq.push_back(mk(0, 1,12, 18'h00C01, 0, 0, 18'h0,     1,12, 18'h00C01, 1, 0, 16'h0040));
    seq.push_back(mk(0, 1,12, 18'h00C02, 0, 0, 18'h0,     1,12, 18'h00C02, 1, 0, 16'h0040));
    seq.push_back(mk(0, 1,12, 18'h00C03, 0, 0, 18'h0,     1,12, 18'h00C03, 1, 0, 16'h0040));
    seq.push_back(mk(0, 1,12, 18'h00C04, 0, 0, 18'h0,     1,12, 18'h00C04, 1, 0, 16'h0040));
    seq.push_back(mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     1, 6, 18'h00066, 1, 1, 16'h0040));
    seq.push_back(mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 18'h0,     1, 0, 16'h0000));
    foreach (seq[i]) run_vec(seq[i], "starve", i);

    // Reset with two entries buffered discards them.
    seq.delete();
    seq.push_back(mk(0, 1, 1, 18'h00001, 1, 7, 18'h00077, 1, 1, 18'h00001, 1, 0, 16'h0000));
    seq.push_back(mk(0, 1, 1, 18'h00002, 1,14, 18'h000EE, 1, 1, 18'h00002, 1, 0, 16'h0080));
    seq.push_back(mk(0, 1, 1, 18'h00003, 0, 0, 18'h0,     1, 1, 18'h00003, 0, 0, 16'h4080));
    seq.push_back(mk(1, 1, 1, 18'h00004, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 16'h0000, 0, 0));
    seq.push_back(mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 18'h0,     1, 0, 16'h0000));
    seq.push_back(mk(0, 0, 0, 18'h0,     0, 0, 18'h0,     0, 0, 18'h0,     1, 0, 16'h0000));
    foreach (seq[i]) run_vec(seq[i], "rstmid", i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
